// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM states and sign helper for the iterative multiply/divide unit
package mdu_pkg;

    // Widest operand the sign helper supports; WIDTH must not exceed this.
    localparam int MDU_MAX_W = 64;

    typedef logic [2*MDU_MAX_W-1:0] mdu_wide_t;

    localparam mdu_wide_t MDU_WIDE_ONE = mdu_wide_t'(1);

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_NOP   = 3'd6
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_FIN
    } mdu_state_e;

    // Callers zero-extend into the wide type and truncate the result back.
    function automatic mdu_wide_t cond_neg(input mdu_wide_t x, input logic neg);
        return neg ? (~x + MDU_WIDE_ONE) : x;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - request/result bundle between the EX stage and the multiply/divide unit
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-division step
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             qbit
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {rem[WIDTH-1:0], din};
    assign diff    = {1'b0, shifted} - {2'b00, divisor};
    // A set top remainder bit means the shifted value already exceeds any divisor.
    assign qbit     = rem[WIDTH] | ~diff[WIDTH+1];
    assign rem_next = qbit ? diff[WIDTH:0] : shifted;
endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit owning the architectural HI/LO registers
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef logic [WIDTH-1:0]   word_t;
    typedef logic [2*WIDTH-1:0] dword_t;

    mdu_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    dword_t           acc;
    logic [WIDTH:0]   rem;
    word_t            md;
    logic             neg_res, neg_rem, zero_div, op_div;
    word_t            hi_q, lo_q;
    logic             dbz_q;

    logic             accept, is_signed, last;
    word_t            mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_nxt;
    logic             qbit;
    dword_t           prod_fix;
    word_t            quo_fix, rem_fix;

    assign accept    = (state == ST_IDLE || state == ST_FIN) && bus.start && !bus.cancel;
    assign is_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
    assign last      = (cnt == CNT_W'(1));

    always_comb begin
        mag_a    = word_t'(cond_neg(mdu_wide_t'(bus.a), is_signed & bus.a[WIDTH-1]));
        mag_b    = word_t'(cond_neg(mdu_wide_t'(bus.b), is_signed & bus.b[WIDTH-1]));
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, md} : '0);
        prod_fix = dword_t'(cond_neg(mdu_wide_t'(acc), neg_res));
        quo_fix  = word_t'(cond_neg(mdu_wide_t'(acc[WIDTH-1:0]), neg_res));
        rem_fix  = word_t'(cond_neg(mdu_wide_t'(rem[WIDTH-1:0]), neg_rem));
    end

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem),
        .din      (acc[WIDTH-1]),
        .divisor  (md),
        .rem_next (rem_nxt),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_FIN: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    case (bus.op)
                        MDU_MULT, MDU_MULTU: state_nxt = ST_MUL;
                        MDU_DIV, MDU_DIVU:   state_nxt = ST_DIV;
                        default:             state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_MUL:  if (last) state_nxt = ST_FIX;
            ST_DIV:  if (last) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_FIN;
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.cancel) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            md       <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            zero_div <= 1'b0;
            op_div   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state)
                ST_MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt - CNT_W'(1);
                end
                ST_DIV: begin
                    rem             <= rem_nxt;
                    acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], qbit};
                    cnt             <= cnt - CNT_W'(1);
                end
                ST_FIX: begin
                    if (!bus.cancel) begin
                        if (!op_div) begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end else if (zero_div) begin
                            dbz_q <= 1'b1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end
                end
                default: ;
            endcase

            if (accept) begin
                if (bus.op[2:1] != 2'b11) dbz_q <= 1'b0;
                case (bus.op)
                    MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                        op_div   <= bus.op[1];
                        // Multiply iterates over b with a as addend; divide shifts a through b.
                        md       <= bus.op[1] ? mag_b : mag_a;
                        acc      <= {word_t'(0), bus.op[1] ? mag_a : mag_b};
                        rem      <= '0;
                        cnt      <= CNT_W'(WIDTH);
                        neg_res  <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem  <= is_signed & bus.a[WIDTH-1];
                        zero_div <= (bus.b == '0);
                    end
                    MDU_MTHI: hi_q <= bus.a;
                    MDU_MTLO: lo_q <= bus.a;
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy        = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
    assign bus.done        = (state == ST_FIN);
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized self-checking bench for mdu_iter against an arithmetic reference model
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mdu_if #(.WIDTH(32)) bus ();

    mdu_iter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic        m_dbz  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Architectural result of one request, from plain integer arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint      sa, sb, sq, sr;
        logic [63:0] p, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = m_hi;
        el = m_lo;
        ed = m_dbz;
        case (op)
            3'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; ed = 1'b0; end
            3'd1: begin p = {32'h0, a} * {32'h0, b}; eh = p[63:32]; el = p[31:0]; ed = 1'b0; end
            3'd2: begin
                ed = (b == 32'h0);
                if (b != 32'h0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    el = sq[31:0];
                    eh = sr[31:0];
                end
            end
            3'd3: begin
                ed = (b == 32'h0);
                if (b != 32'h0) begin
                    uq = {32'h0, a} / {32'h0, b};
                    ur = {32'h0, a} % {32'h0, b};
                    el = uq[31:0];
                    eh = ur[31:0];
                end
            end
            3'd4: begin eh = a; ed = 1'b0; end
            3'd5: begin el = a; ed = 1'b0; end
            default: ;
        endcase
    endtask

    // Entered and left at a falling edge; leaving in the done cycle lets the next call hit FIN.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        ed;
        int          cyc, bcnt;
        model(op, a, b, eh, el, ed);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'd6;
        cyc  = 1;
        bcnt = 0;
        if (op <= 3'd3) begin
            check("dbz_clear_on_start", 64'(bus.div_by_zero), 64'(0));
            while (!bus.done && cyc < 100) begin
                if (bus.busy) bcnt++;
                @(negedge clk);
                cyc++;
            end
            check("done_latency", 64'(cyc), 64'(34));
            check("busy_cycles", 64'(bcnt), 64'(33));
        end else begin
            check("no_done", 64'(bus.done), 64'(0));
            check("no_busy", 64'(bus.busy), 64'(0));
        end
        check("div_by_zero", 64'(bus.div_by_zero), 64'(ed));
        check("hi", 64'(bus.hi), 64'(eh));
        check("lo", 64'(bus.lo), 64'(el));
        m_hi  = eh;
        m_lo  = el;
        m_dbz = ed;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dn;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'd6;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        @(negedge clk);
        check("rst_hi", 64'(bus.hi), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFF, 32'd2);
        check("mult_neg1x2_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
        check("mult_neg1x2_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd4, 32'h1234_5678, 32'd0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd2);
        run_op(3'd4, 32'hAAAA_0000, 32'd0);
        run_op(3'd5, 32'h0000_5555, 32'd0);
        run_op(3'd3, 32'd7, 32'd0);
        run_op(3'd3, 32'd7, 32'd2);
        @(negedge clk);

        // Cancel mid-multiply; a start raised while busy must be dropped.
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd6;
        dn = 0;
        for (int k = 1; k <= 50; k++) begin
            if (k == 3) begin bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD_BEEF; end
            if (k == 6) begin bus.start = 1'b0; bus.op = 3'd6; end
            if (k == 10) begin
                check("busy_before_cancel", 64'(bus.busy), 64'(1));
                bus.cancel = 1'b1;
            end
            if (k == 11) begin
                bus.cancel = 1'b0;
                check("busy_after_cancel", 64'(bus.busy), 64'(0));
            end
            if (bus.done) dn++;
            @(negedge clk);
        end
        check("cancel_no_done", 64'(dn), 64'(0));
        check("cancel_hi_kept", 64'(bus.hi), 64'(m_hi));
        check("cancel_lo_kept", 64'(bus.lo), 64'(m_lo));

        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hCAFE_F00D; bus.cancel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd6; bus.cancel = 1'b0;
        @(negedge clk);
        check("cancel_wins_lo", 64'(bus.lo), 64'(m_lo));

        for (int i = 0; i < 24; i++) begin
            run_op(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
        end
        @(negedge clk);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo", 64'(bus.lo), 64'h0000_0000_8000_0000);
        check("div_ovf_hi", 64'(bus.hi), 64'(0));
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'd6;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_hi", 64'(bus.hi), 64'(0));
        check("async_rst_lo", 64'(bus.lo), 64'(0));
        check("async_rst_busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        @(negedge clk);
        run_op(3'd1, 32'd6, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit that owns the architectural HI/LO registers.
- Successor to the single-cycle combinational MULT/MTHI/MTLO handling in the execute-stage ALU. Adds signed/unsigned DIV, a configurable width, a busy/done handshake for pipeline stalling, and flush cancellation.
- Sits beside the ALU in EX; MFHI/MFLO read its hi/lo outputs directly.

Parameters:
- WIDTH, 32, operand width and HI/LO width; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request: op/a/b sampled when start=1 and unit idle
- op  input  3  operation code (mdu_pkg): MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, 6/7 = NOP
- a  input  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
- b  input  WIDTH  rt operand (multiplier/divisor)
- cancel  input  1  pipeline flush; aborts in-flight op
- busy  output  1  high while an op is iterating; EX stalls on busy
- done  output  1  one-cycle pulse: new HI/LO visible this cycle
- div_by_zero  output  1  sticky per op; set with done of a DIV/DIVU with b=0, cleared at next accepted start
- hi  output  WIDTH  architectural HI
- lo  output  WIDTH  architectural LO

Behaviour:
- Reset (async, rst=1): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter and datapath registers cleared.
- FSM states: IDLE, MUL, DIV, FIX, FIN.
- IDLE, start=1, cancel=0:
  - MULT/MULTU → MUL; DIV/DIVU → DIV.
  - Latch operand magnitudes (abs value for signed ops, raw for unsigned), the result-sign flags, and counter=WIDTH.
- IDLE, start=1, MTHI/MTLO: hi (resp. lo) ← a at that edge; no busy, no done; state stays IDLE.
- IDLE, start=1, op 6/7: no effect.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 2·WIDTH accumulator. Counter decrements; at counter==1 → FIX.
- DIV: restoring shift-subtract; each cycle produces one quotient bit, partial remainder WIDTH+1 bits. At counter==1 → FIX.
- FIX (one cycle): apply sign correction.
  - Signed product is negated if operand signs differ.
  - Signed quotient is negated if signs differ.
  - Remainder takes the sign of the dividend.
  - Registered: hi←product[2W-1:W], lo←product[W-1:0]; for divide hi←remainder, lo←quotient.
  - Then → FIN.
- FIN: done=1 for this single cycle; hi/lo already hold the new values; busy=0; → IDLE.
- Latency: start sampled at edge T; busy=1 in cycles T+1 … T+WIDTH+1; done=1 in cycle T+WIDTH+2 (34 cycles for WIDTH=32). A new start is accepted in the FIN cycle.
- start while busy=1 is ignored; upstream holds the request (stall).
- Divide by zero: the full latency still elapses, hi/lo are NOT written, and div_by_zero=1 together with done.
- Signed overflow (−2^(W−1) ÷ −1): lo=0x8000_0000, hi=0 (W=32). Truncated, no trap.
- cancel=1 in any non-IDLE state: next state IDLE, hi/lo unchanged, no done, busy=0 next cycle.
- cancel=1 in FIN: done still asserts (write already committed).
- cancel and start both high in IDLE: cancel wins, nothing accepted (MTHI/MTLO included).
- rst mid-operation: immediate abort to reset values.

Decomposition:
- mdu_pkg holds:
  - the op code localparams/enum (MDU_MULT … MDU_NOP)
  - the FSM state enum
  - a result-sign helper function (conditional two's-complement negate).
- One natural sub-module, mdu_div_step: combinational single restoring step. Inputs: partial remainder, next dividend bit, divisor. Outputs: new remainder and quotient bit. Instantiated once inside mdu_iter.

Test Plan:
- MULT a=0xFFFFFFFF (−1), b=2 → done at start+34; hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE. Then MTHI a=0x12345678 → hi=0x12345678 next cycle, lo unchanged, no done.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIVU a=7, b=2 → lo=3, hi=1.
- Preload hi=0xAAAA0000, lo=0x5555; DIVU a=7, b=0 → done at +34, div_by_zero=1, hi/lo unchanged; next start clears div_by_zero.
- MULT a=3, b=5, cancel pulsed at start+10 → busy=0 at start+11, no done ever, hi/lo keep prior values; a start issued during busy is never executed.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Assert rst at start+5 → hi=lo=0, busy=0 immediately (async).
